// File: rtl/dual_edge_clock_divider_if.sv
// Control and output bundle for the dual-edge clock divider.
// The master side sets the divide ratio, mode and run enable; the slave side
// (the divider) returns the divided waveform, period strobe and clamp flag.
interface dual_edge_clock_divider_if #(
  parameter int WIDTH = 4
);
  logic             Enable;
  logic [WIDTH-1:0] Divisor;
  logic             Mode;
  logic             ClkOut;
  logic             Tick;
  logic             DivErr;

  modport master (output Enable, Divisor, Mode, input ClkOut, Tick, DivErr);
  modport slave  (input Enable, Divisor, Mode, output ClkOut, Tick, DivErr);
endinterface

// File: rtl/dual_edge_clock_divider.sv
// Programmable clock divider / waveform generator.
// A posedge period counter drives a posedge waveform register P; a negedge
// copy Nq stretches the high phase by half a cycle so odd divisors give an
// exact 50% duty. ClkOut only muxes/ORs registered values, Clock is never gated.
module dual_edge_clock_divider #(
  parameter int WIDTH = 4
) (
  input  logic                      Clock,
  input  logic                      Reset,
  dual_edge_clock_divider_if.slave  bus
);

  logic [WIDTH-1:0] count, count_n;
  logic [WIDTH-1:0] d, d_n;
  logic [WIDTH-1:0] h_n;
  logic             m, m_n;
  logic             derr, derr_n;
  logic             p, p_n;
  logic             tick, tick_n;
  logic             run;
  logic             nq;
  logic             wrap, start, load;

  // Next-state for counter, active config and posedge waveform/strobe.
  always_comb begin
    wrap    = run && (count == d - WIDTH'(1));
    // A rising Enable begins a fresh period at count 0 and takes the current
    // Divisor/Mode, just like a wrap does.
    start   = bus.Enable && !run;
    load    = !bus.Enable || wrap || start;
    d_n     = d;
    m_n     = m;
    derr_n  = derr;
    if (load) begin
      m_n = bus.Mode;
      if (bus.Divisor < WIDTH'(2)) begin
        d_n    = WIDTH'(2);
        derr_n = 1'b1;
      end else begin
        d_n    = bus.Divisor;
        derr_n = 1'b0;
      end
    end
    if (!bus.Enable || start || wrap) count_n = '0;
    else                              count_n = count + WIDTH'(1);
    h_n    = d_n >> 1;
    p_n    = bus.Enable && (m_n ? (count_n == '0) : (count_n < h_n));
    tick_n = bus.Enable && (count_n == '0);
  end

  // Posedge domain state: counter, config, waveform and strobe registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      d     <= WIDTH'(2);
      m     <= 1'b0;
      derr  <= 1'b0;
      p     <= 1'b0;
      tick  <= 1'b0;
      run   <= 1'b0;
    end else begin
      count <= count_n;
      d     <= d_n;
      m     <= m_n;
      derr  <= derr_n;
      p     <= p_n;
      tick  <= tick_n;
      run   <= bus.Enable;
    end
  end

  // Negedge half-cycle stretch: delayed copy of P.
  always_ff @(negedge Clock or posedge Reset) begin
    if (Reset) nq <= 1'b0;
    else       nq <= p;
  end

  // Odd square-wave divisors use P|Nq for the extra half cycle; otherwise P.
  assign bus.ClkOut = (!m && d[0]) ? (p | nq) : p;
  assign bus.Tick   = tick;
  assign bus.DivErr = derr;

endmodule

// File: tb/tb_dual_edge_clock_divider.sv
// Directed bench for dual_edge_clock_divider: checks ClkOut on both clock
// phases, Tick and DivErr against hand-derived waveforms per count position.
module tb_dual_edge_clock_divider;
  localparam int WIDTH = 4;

  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  dual_edge_clock_divider_if #(.WIDTH(WIDTH)) bus ();

  dual_edge_clock_divider #(.WIDTH(WIDTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One enabled cycle at count position k of a period with divisor d, mode m.
  // Square wave: high for counts < d/2, plus the posedge half of count d/2
  // when d is odd. Pulse: high only at count 0.
  task automatic cyc(input int d, input bit m, input int k, input bit derr);
    logic hp, hn;
    int   h;
    h = d / 2;
    if (m) begin
      hp = (k == 0);
      hn = hp;
    end else begin
      hn = (k < h);
      hp = (k < h) || ((d % 2 == 1) && (k == h));
    end
    @(posedge Clock); #1;
    chk($sformatf("clk_hi_half d=%0d m=%0d k=%0d", d, m, k), bus.ClkOut, hp);
    chk($sformatf("tick d=%0d m=%0d k=%0d", d, m, k), bus.Tick, k == 0);
    chk($sformatf("diverr d=%0d k=%0d", d, k), bus.DivErr, derr);
    @(negedge Clock); #1;
    chk($sformatf("clk_lo_half d=%0d m=%0d k=%0d", d, m, k), bus.ClkOut, hn);
  endtask

  task automatic period(input int d, input bit m, input bit derr);
    for (int k = 0; k < d; k++) cyc(d, m, k, derr);
  endtask

  // One halted cycle: Tick must stay low.
  task automatic halt_cyc(input logic hp, input logic hn, input string tag);
    @(posedge Clock); #1;
    chk({tag, "_clk_p"}, bus.ClkOut, hp);
    chk({tag, "_tick"}, bus.Tick, 1'b0);
    @(negedge Clock); #1;
    chk({tag, "_clk_n"}, bus.ClkOut, hn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset       = 1'b1;
    bus.Enable  = 1'b0;
    bus.Divisor = 4'd4;
    bus.Mode    = 1'b0;
    #1;
    chk("rst_clkout", bus.ClkOut, 1'b0);
    chk("rst_tick", bus.Tick, 1'b0);
    chk("rst_diverr", bus.DivErr, 1'b0);
    #1;
    Reset      = 1'b0;
    bus.Enable = 1'b1;

    // Divide by 4, square wave: 2 high / 2 low, Tick at rise.
    period(4, 0, 0);
    period(4, 0, 0);

    // Divide by 5: 2.5 high / 2.5 low.
    bus.Divisor = 4'd5;
    period(5, 0, 0);
    period(5, 0, 0);

    // Pulse mode, divide by 3; then change to 6 mid-period.
    bus.Divisor = 4'd3;
    bus.Mode    = 1'b1;
    period(3, 1, 0);
    cyc(3, 1, 0, 0);
    bus.Divisor = 4'd6;
    cyc(3, 1, 1, 0);
    cyc(3, 1, 2, 0);
    period(6, 1, 0);

    // Clamped divisors 0 and 1 behave as divide-by-2 with DivErr set.
    bus.Divisor = 4'd0;
    bus.Mode    = 1'b0;
    period(2, 0, 1);
    period(2, 0, 1);
    bus.Divisor = 4'd1;
    period(2, 0, 1);
    cyc(2, 0, 0, 1);
    bus.Divisor = 4'd7;
    cyc(2, 0, 1, 1);
    period(7, 0, 0);

    // Maximum divisor 15: 7.5 / 7.5, then halt at count 3.
    bus.Divisor = 4'd15;
    period(15, 0, 0);
    for (int k = 0; k < 4; k++) cyc(15, 0, k, 0);
    bus.Enable = 1'b0;
    halt_cyc(1'b1, 1'b0, "halt15_a");
    halt_cyc(1'b0, 1'b0, "halt15_b");
    bus.Enable = 1'b1;
    for (int k = 0; k < 3; k++) cyc(15, 0, k, 0);

    // Switch to divide by 5 through a short halt.
    bus.Enable  = 1'b0;
    bus.Divisor = 4'd5;
    halt_cyc(1'b1, 1'b0, "halt5_a");
    halt_cyc(1'b0, 1'b0, "halt5_b");
    bus.Enable = 1'b1;
    cyc(5, 0, 0, 0);

    // Asynchronous reset while ClkOut and Tick are high.
    chk("pre_rst_clkout", bus.ClkOut, 1'b1);
    Reset = 1'b1;
    #1;
    chk("async_rst_clkout", bus.ClkOut, 1'b0);
    chk("async_rst_tick", bus.Tick, 1'b0);
    chk("async_rst_diverr", bus.DivErr, 1'b0);
    @(posedge Clock); #1;
    chk("held_rst_clkout", bus.ClkOut, 1'b0);
    chk("held_rst_tick", bus.Tick, 1'b0);
    @(negedge Clock); #1;
    Reset = 1'b0;
    period(5, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
